// File: rtl/core_pkg.sv
// Shared integer-register-file constants and types.
// Used by the writeback register file and its load scoreboard.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when a live writeback targets a non-zero register the reader is asking for.
    function automatic logic wb_hits(input logic we, input reg_addr_t wa, input reg_addr_t ra);
        return we && (wa == ra) && (ra != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by load issue, cleared by
// writeback or flush, and a combinational load-use stall for the two ID read ports.
module wb_scoreboard
    import core_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      wb_we,
    input  reg_addr_t wb_addr,
    input  logic      sb_set,
    input  reg_addr_t sb_addr,
    input  logic      sb_flush,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      stall
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_d;
    logic             w_pend1;
    logic             w_pend2;

    // Later assignments win: writeback clear, then flush, then a younger load's set.
    always_comb begin
        w_pend_d = r_pend;
        if (wb_we && (wb_addr != REG_ZERO)) begin
            w_pend_d[wb_addr] = 1'b0;
        end
        if (sb_flush) begin
            w_pend_d = '0;
        end
        if (sb_set && (sb_addr != REG_ZERO)) begin
            w_pend_d[sb_addr] = 1'b1;
        end
        w_pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    // Without bypass the reader cannot see the writeback data, so the stall holds one more cycle.
    always_comb begin
        w_pend1 = r_pend[rs1_addr] && (rs1_addr != REG_ZERO);
        w_pend2 = r_pend[rs2_addr] && (rs2_addr != REG_ZERO);
        if (BYPASS_EN) begin
            w_pend1 = w_pend1 && !wb_hits(wb_we, wb_addr, rs1_addr);
            w_pend2 = w_pend2 && !wb_hits(wb_we, wb_addr, rs2_addr);
        end
        stall = w_pend1 || w_pend2;
    end

endmodule

// File: rtl/regfile_wb.sv
// Integer register file at the MEM/WB boundary: two bypassed combinational read
// ports, a pending-load scoreboard for load-use stalls and a registered debug port.
module regfile_wb
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = core_pkg::XLEN,
    parameter int unsigned NREGS     = core_pkg::NREGS,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_addr,
    input  logic              sb_flush,
    output logic              stall,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] r_dbg;

    // Flop array rather than RAM so the whole file clears on the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != REG_ZERO)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == REG_ZERO) begin
            return '0;
        end
        if (BYPASS_EN && wb_hits(wb_we, wb_addr, addr)) begin
            return wb_data;
        end
        return r_regs[addr];
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbg <= '0;
        end else if (dbg_addr == REG_ZERO) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= r_regs[dbg_addr];
        end
    end

    assign dbg_data = r_dbg;

    wb_scoreboard #(
        .BYPASS_EN (BYPASS_EN)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .sb_flush (sb_flush),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .stall    (stall)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios with literal expectations, then random
// traffic compared every cycle against an array-based reference model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        sb_flush;
    logic        stall;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [31:0] m_dbg;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk      (clk),
        .reset    (reset),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .sb_flush (sb_flush),
        .stall    (stall),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit pend_live(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !(wb_we && wb_addr == a);
    endfunction

    function automatic bit exp_stall();
        return pend_live(rs1_addr) || pend_live(rs2_addr);
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Reference model: architectural state updated by the rules, not by RTL structure.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_pend[i] <= 1'b0;
            end
            m_dbg <= 32'd0;
        end else begin
            m_dbg <= (dbg_addr == 5'd0) ? 32'd0 : m_regs[dbg_addr];
            if (wb_we && wb_addr != 5'd0) begin
                m_regs[wb_addr] <= wb_data;
                m_pend[wb_addr] <= 1'b0;
            end
            if (sb_flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
            end
            if (sb_set && sb_addr != 5'd0) m_pend[sb_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rs1", rs1_data, exp_rd(rs1_addr));
            check("cmp_rs2", rs2_data, exp_rd(rs2_addr));
            check("cmp_stall", {31'd0, stall}, {31'd0, exp_stall()});
            check("cmp_dbg", dbg_data, m_dbg);
        end
    end

    task automatic idle();
        wb_data  = 32'd0;
        wb_addr  = 5'd0;
        wb_we    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        sb_set   = 1'b0;
        sb_addr  = 5'd0;
        sb_flush = 1'b0;
        dbg_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #1;
        check("rst_rs1", rs1_data, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dbg", dbg_data, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b1;
        chk_en = 1'b1;

        // All addresses read zero after reset.
        for (int a = 0; a < 32; a++) begin
            step();
            idle();
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            dbg_addr = 5'(a);
            #1;
            check("t1_rs1", rs1_data, 32'd0);
            check("t1_rs2", rs2_data, 32'd0);
            check("t1_stall", {31'd0, stall}, 32'd0);
        end
        step();
        idle();
        #1;
        check("t1_dbg", dbg_data, 32'd0);

        // Same-cycle bypass, then debug readback.
        step();
        idle();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        check("t2_bypass", rs1_data, 32'hDEADBEEF);
        step();
        idle();
        dbg_addr = 5'd5;
        step();
        idle();
        rs1_addr = 5'd5;
        #1;
        check("t2_dbg", dbg_data, 32'hDEADBEEF);
        check("t2_stored", rs1_data, 32'hDEADBEEF);

        // x0 writes and x0 scoreboard sets are ignored.
        step();
        idle();
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
        sb_set = 1'b1; sb_addr = 5'd0;
        #1;
        check("t3_x0_bypass", rs1_data, 32'd0);
        step();
        idle();
        dbg_addr = 5'd0;
        #1;
        check("t3_x0_stall", {31'd0, stall}, 32'd0);
        step();
        idle();
        #1;
        check("t3_x0_dbg", dbg_data, 32'd0);

        // Load-use stall held, then released by the same-cycle writeback.
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd7;
        step();
        idle();
        rs2_addr = 5'd7;
        #1;
        check("t4_stall", {31'd0, stall}, 32'd1);
        step();
        idle();
        rs2_addr = 5'd7;
        #1;
        check("t4_stall_held", {31'd0, stall}, 32'd1);
        step();
        idle();
        rs2_addr = 5'd7; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1;
        check("t4_release", {31'd0, stall}, 32'd0);
        check("t4_rs2_bypass", rs2_data, 32'h55);
        step();
        idle();
        rs2_addr = 5'd7;
        #1;
        check("t4_cleared", {31'd0, stall}, 32'd0);
        check("t4_rs2", rs2_data, 32'h55);

        // Set wins over same-cycle writeback clear and over flush.
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd9; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        step();
        idle();
        rs1_addr = 5'd9;
        #1;
        check("t5_set_wins", {31'd0, stall}, 32'd1);
        check("t5_rs1", rs1_data, 32'h99);
        step();
        idle();
        sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd10;
        step();
        idle();
        rs1_addr = 5'd9;
        #1;
        check("t5_flushed9", {31'd0, stall}, 32'd0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd10;
        #1;
        check("t5_pend10", {31'd0, stall}, 32'd1);
        step();
        idle();
        sb_flush = 1'b1;

        // Asynchronous reset mid-operation drops the in-flight write.
        step();
        idle();
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
        sb_set = 1'b1; sb_addr = 5'd11;
        step();
        idle();
        dbg_addr = 5'd3;
        step();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd11; dbg_addr = 5'd3;
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
        #1;
        check("t6_pre_stall", {31'd0, stall}, 32'd1);
        check("t6_pre_rs1", rs1_data, 32'hA5A5A5A5);
        check("t6_pre_dbg", dbg_data, 32'hA5A5A5A5);
        #1;
        reset = 1'b0;
        #1;
        check("t6_rst_rs1", rs1_data, 32'd0);
        check("t6_rst_stall", {31'd0, stall}, 32'd0);
        check("t6_rst_dbg", dbg_data, 32'd0);
        step();
        idle();
        rs1_addr = 5'd4;
        step();
        reset = 1'b1;
        rs1_addr = 5'd4;
        #1;
        check("t6_x4_rs1", rs1_data, 32'd0);
        step();
        idle();
        dbg_addr = 5'd4;
        step();
        idle();
        #1;
        check("t6_x4_dbg", dbg_data, 32'd0);

        // Random traffic; ID never issues a load while stalled.
        for (int n = 0; n < 3000; n++) begin
            step();
            rs1_addr = rnd_addr();
            rs2_addr = rnd_addr();
            wb_we    = 1'($urandom_range(0, 1));
            wb_addr  = rnd_addr();
            wb_data  = $urandom();
            dbg_addr = rnd_addr();
            sb_flush = ($urandom_range(0, 19) == 0);
            sb_addr  = rnd_addr();
            sb_set   = ($urandom_range(0, 3) == 0) && !exp_stall();
        end
        step();
        idle();
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
